uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares one UART transmitter among `N_REQ` byte-stream requesters. It owns the transmitter's start/data inputs and sequences one byte at a time: accept, launch, wait for completion. A message lock keeps the grant on one requester until that requester's last byte, so multi-byte messages are never interleaved. It sits between the command/response producers and `uart_tx`, which runs on the same `clk` and baud tick domain as `uart_rx`.

## Interface

Parameters:
- `N_REQ`, default 4: number of requesters, 2..8.
- `DATA_W`, default 8: byte width.
- `LOCK_TIMEOUT`, default 1024: maximum number of idle cycles a locked requester may leave between bytes before the lock is force-released.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `req_valid`, in, N_REQ: per-requester byte-valid.
- `req_data`, in, N_REQ*DATA_W: requester i's byte is `[i*DATA_W +: DATA_W]`.
- `req_last`, in, N_REQ: the presented byte ends its message.
- `req_ready`, out, N_REQ: one-hot or zero. A transfer occurs when `req_valid[i] && req_ready[i]`.
- `tx_start`, out, 1: one-cycle pulse that launches `tx_data` on `uart_tx`.
- `tx_data`, out, DATA_W: byte to send; held stable from `tx_start` until `tx_done`.
- `tx_busy`, in, 1: transmitter is shifting.
- `tx_done`, in, 1: one-cycle pulse at the end of the stop bit.
- `grant_id`, out, $clog2(N_REQ): current or last granted requester.
- `lock_active`, out, 1: a message is in progress.
- `lock_timeout`, out, 1: one-cycle pulse when a lock is force-released.

## Operation

- States: IDLE, LAUNCH, WAIT_DONE, HOLD.
- **IDLE**
  - Select the first requester with valid set, searching from `rr_ptr+1` and wrapping modulo N_REQ.
  - `req_ready` for that requester is driven combinationally in the same cycle.
  - On transfer: capture the byte into `tx_data` and `req_last` into `last_q`, set `grant_id`, go to LAUNCH.
  - With no valid requester, stay in IDLE.
- **LAUNCH**
  - If `tx_busy` is 0: pulse `tx_start`, go to WAIT_DONE.
  - Otherwise wait in LAUNCH; no timeout.
- **WAIT_DONE**, on `tx_done`:
  - If `last_q` is 1: clear the lock, set `rr_ptr` to `grant_id`, go to IDLE.
  - Otherwise: set the lock, clear the timeout counter, go to HOLD.
- **HOLD**
  - `req_ready` is asserted only to `grant_id` while it is valid. All other requesters are masked.
  - On transfer: go to LAUNCH as in IDLE.
  - Each cycle without a transfer increments the counter. When the counter reaches `LOCK_TIMEOUT-1`: pulse `lock_timeout`, clear the lock, set `rr_ptr` to `grant_id`, go to IDLE.
- `lock_active` is 1 from the first non-last byte's `tx_done` until release, and also while the FSM is in LAUNCH or WAIT_DONE inside a message.
- `tx_done` in any state other than WAIT_DONE is ignored.
- `req_ready` is 0 in LAUNCH and WAIT_DONE.
- Requesters hold `valid`, `data` and `last` stable until the transfer occurs.

## Timing

- Reset values:
  - State IDLE.
  - `rr_ptr` = N_REQ-1, so requester 0 wins first.
  - `tx_start`, `tx_data`, `grant_id`, `lock_active`, `lock_timeout` and the counter are 0.
  - `req_ready` is 0.
- Reset asserted mid-byte drops the FSM to IDLE immediately. The in-flight `uart_tx` byte completes independently, and its `tx_done` is ignored.
- Latency with `tx_busy` low: transfer at cycle 0, `tx_start` at cycle 1.
- Back-to-back throughput: the next transfer can occur in the cycle after `tx_done`. Minimum inter-byte gap is 1 cycle plus the UART frame time.
- Outputs `tx_start`, `tx_data`, `grant_id`, `lock_active` and `lock_timeout` are registered. Only `req_ready` is combinational, from the state, `req_valid` and `rr_ptr`.
- Timeout counter width is $clog2(LOCK_TIMEOUT+1). It saturates and never wraps.

## Structure

- Shared package `uart_pkg`: state encoding constants (IDLE=0, LAUNCH=1, WAIT_DONE=2, HOLD=3) and `UART_DATA_W`=8.
- One natural sub-module, `rr_select`: a combinational round-robin priority picker. Inputs are the `req_valid` vector and `rr_ptr`; outputs are a one-hot grant, its index, and an any-valid flag.
- The FSM, data/last capture and timeout counter stay in `uart_tx_arbiter`.

## Test plan

- Reset release, all four requesters valid with `last`=1 and data 0x10..0x13 → `tx_start` order is requester 0,1,2,3 with bytes 0x10,0x11,0x12,0x13. Each `tx_start` follows its `tx_done` by exactly 2 cycles.
- Requester 2 sends message A1,A2,A3 (`last` on A3) while requester 1 is continuously valid → A1,A2,A3 go out contiguously, then requester 1's byte. `lock_active` falls on A3's `tx_done`.
- Requester 0 locked mid-message drops `valid` for LOCK_TIMEOUT=16 cycles while requester 3 is valid → `lock_timeout` pulses once, and requester 3 is granted next.
- `tx_busy` held high for 50 cycles after a transfer → FSM stays in LAUNCH, and a single `tx_start` fires in the cycle after `tx_busy` falls.
- Stray `tx_done` pulse while in IDLE or LAUNCH → no state change and no extra `tx_start`.
- `rst` asserted while in WAIT_DONE → the next cycle shows state IDLE, all outputs 0, and requester 0 has priority again.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions.
//   UART_DATA_W : default byte width of the UART datapath.
//   state_e     : uart_tx_arbiter FSM encoding (IDLE=0, LAUNCH=1, WAIT_DONE=2, HOLD=3).
package uart_pkg;

  localparam int unsigned UART_DATA_W = 8;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StLaunch   = 2'd1,
    StWaitDone = 2'd2,
    StHold     = 2'd3
  } state_e;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin priority picker.
// Searches req_valid starting at rr_ptr+1 and wrapping modulo N_REQ; the
// first valid requester found wins.
//   req_valid : per-requester valid vector
//   rr_ptr    : index of the most recently served requester
//   grant     : one-hot grant (all zero when nothing is valid)
//   grant_idx : index of the granted requester (0 when nothing is valid)
//   any_valid : at least one requester is valid
module rr_select #(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned IW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [IW-1:0]    rr_ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    grant_idx,
  output logic             any_valid
);

  always_comb begin
    int unsigned idx;
    idx       = 0;
    grant     = '0;
    grant_idx = '0;
    any_valid = 1'b0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      idx = (32'(rr_ptr) + off) % N_REQ;
      if (!any_valid && req_valid[idx]) begin
        any_valid  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among N_REQ byte-stream requesters.
// Bytes are accepted one at a time, launched on the transmitter and waited on
// until tx_done. A non-last byte locks the grant to its requester so multi-byte
// messages are never interleaved; an idle lock is force-released after
// LOCK_TIMEOUT cycles.
//   clk, rst     : clock, asynchronous active-high reset
//   req_valid    : per-requester byte valid
//   req_data     : requester i's byte at [i*DATA_W +: DATA_W]
//   req_last     : presented byte ends its message
//   req_ready    : one-hot or zero accept (combinational)
//   tx_start     : one-cycle launch pulse to uart_tx
//   tx_data      : byte to send, stable from tx_start until tx_done
//   tx_busy      : transmitter is shifting
//   tx_done      : end-of-stop-bit pulse from uart_tx
//   grant_id     : current or last granted requester
//   lock_active  : a message is in progress
//   lock_timeout : one-cycle pulse when a lock is force-released
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned DATA_W       = UART_DATA_W,
  parameter int unsigned LOCK_TIMEOUT = 1024,
  localparam int unsigned IDW         = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    tx_start,
  output logic [DATA_W-1:0]       tx_data,
  input  logic                    tx_busy,
  input  logic                    tx_done,
  output logic [IDW-1:0]          grant_id,
  output logic                    lock_active,
  output logic                    lock_timeout
);

  localparam int unsigned CNT_W = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic                last_q, last_d;
  logic [IDW-1:0]      grant_q, grant_d;
  logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
  logic                lock_q, lock_d;
  logic                tx_start_q, tx_start_d;
  logic                lock_timeout_q, lock_timeout_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [N_REQ-1:0]    sel_grant;
  logic [IDW-1:0]      sel_idx;
  logic                sel_any;

  logic [IDW-1:0]      xfer_idx;
  logic [DATA_W-1:0]   xfer_byte;
  logic                xfer_last;

  rr_select #(
    .N_REQ (N_REQ)
  ) u_rr_select (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant     (sel_grant),
    .grant_idx (sel_idx),
    .any_valid (sel_any)
  );

  // Only HOLD bypasses the round-robin pick: the lock owner is the sole candidate.
  always_comb begin
    xfer_idx  = (state_q == StHold) ? grant_q : sel_idx;
    xfer_byte = req_data[xfer_idx*DATA_W +: DATA_W];
    xfer_last = req_last[xfer_idx];
  end

  // Ready is held low during reset so nothing can appear accepted.
  always_comb begin
    req_ready = '0;
    if (!rst) begin
      case (state_q)
        StIdle: req_ready = sel_grant;
        StHold: if (req_valid[grant_q]) req_ready[grant_q] = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d        = state_q;
    tx_data_d      = tx_data_q;
    last_d         = last_q;
    grant_d        = grant_q;
    rr_ptr_d       = rr_ptr_q;
    lock_d         = lock_q;
    cnt_d          = cnt_q;
    tx_start_d     = 1'b0;
    lock_timeout_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (sel_any) begin
          tx_data_d  = xfer_byte;
          last_d     = xfer_last;
          grant_d    = sel_idx;
          // Launch straight away when the transmitter is free so tx_start is
          // visible in the cycle after the transfer.
          tx_start_d = !tx_busy;
          state_d    = StLaunch;
        end
      end

      StLaunch: begin
        // tx_start_q high means the pulse is on the wire this cycle.
        if (tx_start_q) begin
          state_d = StWaitDone;
        end else if (!tx_busy) begin
          tx_start_d = 1'b1;
        end
      end

      StWaitDone: begin
        if (tx_done) begin
          if (last_q) begin
            lock_d   = 1'b0;
            rr_ptr_d = grant_q;
            state_d  = StIdle;
          end else begin
            lock_d  = 1'b1;
            cnt_d   = '0;
            state_d = StHold;
          end
        end
      end

      StHold: begin
        if (req_valid[grant_q]) begin
          tx_data_d  = xfer_byte;
          last_d     = xfer_last;
          tx_start_d = !tx_busy;
          state_d    = StLaunch;
        end else if (cnt_q == CNT_LAST) begin
          lock_timeout_d = 1'b1;
          lock_d         = 1'b0;
          rr_ptr_d       = grant_q;
          cnt_d          = '0;
          state_d        = StIdle;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      tx_data_q      <= '0;
      last_q         <= 1'b0;
      grant_q        <= '0;
      rr_ptr_q       <= IDW'(N_REQ - 1);
      lock_q         <= 1'b0;
      tx_start_q     <= 1'b0;
      lock_timeout_q <= 1'b0;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      tx_data_q      <= tx_data_d;
      last_q         <= last_d;
      grant_q        <= grant_d;
      rr_ptr_q       <= rr_ptr_d;
      lock_q         <= lock_d;
      tx_start_q     <= tx_start_d;
      lock_timeout_q <= lock_timeout_d;
      cnt_q          <= cnt_d;
    end
  end

  assign tx_start     = tx_start_q;
  assign tx_data      = tx_data_q;
  assign grant_id     = grant_q;
  assign lock_active  = lock_q;
  assign lock_timeout = lock_timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (N_REQ=4, DATA_W=8, LOCK_TIMEOUT=16).
// A table of per-cycle vectors covers round-robin order and message locking;
// hand-written sequences cover lock timeout, a long tx_busy stall with stray
// tx_done pulses, and reset while waiting for tx_done.
module tb_uart_tx_arbiter;

  localparam int unsigned N_REQ  = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned LT     = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        tx_done;
  logic [1:0]  grant_id;
  logic        lock_active;
  logic        lock_timeout;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N_REQ        (N_REQ),
    .DATA_W       (DATA_W),
    .LOCK_TIMEOUT (LT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .tx_busy      (tx_busy),
    .tx_done      (tx_done),
    .grant_id     (grant_id),
    .lock_active  (lock_active),
    .lock_timeout (lock_timeout)
  );

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic [3:0]  last;
    logic        done;
    logic [3:0]  ready;
    logic        start;
    logic [7:0]  txd;
    logic [1:0]  gid;
    logic        lock;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] v, input logic [31:0] d, input logic [3:0] l,
                     input logic dn, input logic [3:0] rdy, input logic st,
                     input logic [7:0] txd, input logic [1:0] g, input logic lk);
    vec_t e;
    e.valid = v;  e.data = d;    e.last = l;   e.done = dn;
    e.ready = rdy; e.start = st; e.txd = txd;  e.gid = g;  e.lock = lk;
    vecs.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".ready"}, 32'(req_ready), 32'd0);
    chk({tag, ".start"}, 32'(tx_start), 32'd0);
    chk({tag, ".data"}, 32'(tx_data), 32'd0);
    chk({tag, ".grant"}, 32'(grant_id), 32'd0);
    chk({tag, ".lock"}, 32'(lock_active), 32'd0);
    chk({tag, ".timeout"}, 32'(lock_timeout), 32'd0);
  endtask

  initial begin
    logic [31:0] d1;
    int          k;
    int          bad;
    int          starts;

    d1 = 32'h13121110;
    // Round robin: all four valid with last=1, one byte each.
    add(4'b1111, d1, 4'hF, 0, 4'b0001, 0, 8'h00, 2'd0, 0);
    add(4'b1110, d1, 4'hF, 0, 4'b0000, 1, 8'h10, 2'd0, 0);
    add(4'b1110, d1, 4'hF, 0, 4'b0000, 0, 8'h10, 2'd0, 0);
    add(4'b1110, d1, 4'hF, 1, 4'b0000, 0, 8'h10, 2'd0, 0);
    add(4'b1110, d1, 4'hF, 0, 4'b0010, 0, 8'h10, 2'd0, 0);
    add(4'b1100, d1, 4'hF, 0, 4'b0000, 1, 8'h11, 2'd1, 0);
    add(4'b1100, d1, 4'hF, 0, 4'b0000, 0, 8'h11, 2'd1, 0);
    add(4'b1100, d1, 4'hF, 1, 4'b0000, 0, 8'h11, 2'd1, 0);
    add(4'b1100, d1, 4'hF, 0, 4'b0100, 0, 8'h11, 2'd1, 0);
    add(4'b1000, d1, 4'hF, 0, 4'b0000, 1, 8'h12, 2'd2, 0);
    add(4'b1000, d1, 4'hF, 0, 4'b0000, 0, 8'h12, 2'd2, 0);
    add(4'b1000, d1, 4'hF, 1, 4'b0000, 0, 8'h12, 2'd2, 0);
    add(4'b1000, d1, 4'hF, 0, 4'b1000, 0, 8'h12, 2'd2, 0);
    add(4'b0000, d1, 4'hF, 0, 4'b0000, 1, 8'h13, 2'd3, 0);
    add(4'b0000, d1, 4'hF, 0, 4'b0000, 0, 8'h13, 2'd3, 0);
    add(4'b0000, d1, 4'hF, 1, 4'b0000, 0, 8'h13, 2'd3, 0);
    add(4'b0000, d1, 4'hF, 0, 4'b0000, 0, 8'h13, 2'd3, 0);
    // Message A1,A2,A3 from requester 2 while requester 1 waits.
    add(4'b0100, 32'h00A15500, 4'b0010, 0, 4'b0100, 0, 8'h13, 2'd3, 0);
    add(4'b0110, 32'h00A25500, 4'b0010, 0, 4'b0000, 1, 8'hA1, 2'd2, 0);
    add(4'b0110, 32'h00A25500, 4'b0010, 0, 4'b0000, 0, 8'hA1, 2'd2, 0);
    add(4'b0110, 32'h00A25500, 4'b0010, 1, 4'b0000, 0, 8'hA1, 2'd2, 0);
    add(4'b0010, 32'h00A25500, 4'b0010, 0, 4'b0000, 0, 8'hA1, 2'd2, 1);
    add(4'b0110, 32'h00A25500, 4'b0010, 0, 4'b0100, 0, 8'hA1, 2'd2, 1);
    add(4'b0110, 32'h00A35500, 4'b0110, 0, 4'b0000, 1, 8'hA2, 2'd2, 1);
    add(4'b0110, 32'h00A35500, 4'b0110, 0, 4'b0000, 0, 8'hA2, 2'd2, 1);
    add(4'b0110, 32'h00A35500, 4'b0110, 1, 4'b0000, 0, 8'hA2, 2'd2, 1);
    add(4'b0110, 32'h00A35500, 4'b0110, 0, 4'b0100, 0, 8'hA2, 2'd2, 1);
    add(4'b0010, 32'h00A35500, 4'b0010, 0, 4'b0000, 1, 8'hA3, 2'd2, 1);
    add(4'b0010, 32'h00A35500, 4'b0010, 0, 4'b0000, 0, 8'hA3, 2'd2, 1);
    add(4'b0010, 32'h00A35500, 4'b0010, 1, 4'b0000, 0, 8'hA3, 2'd2, 1);
    add(4'b0010, 32'h00A35500, 4'b0010, 0, 4'b0010, 0, 8'hA3, 2'd2, 0);
    add(4'b0000, 32'h00A35500, 4'b0010, 0, 4'b0000, 1, 8'h55, 2'd1, 0);
    add(4'b0000, 32'h00A35500, 4'b0010, 0, 4'b0000, 0, 8'h55, 2'd1, 0);
    add(4'b0000, 32'h00A35500, 4'b0010, 1, 4'b0000, 0, 8'h55, 2'd1, 0);
    add(4'b0000, 32'h00A35500, 4'b0010, 0, 4'b0000, 0, 8'h55, 2'd1, 0);

    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tx_busy   = 1'b0;
    tx_done   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      req_valid = vecs[i].valid;
      req_data  = vecs[i].data;
      req_last  = vecs[i].last;
      tx_done   = vecs[i].done;
      #1;
      chk($sformatf("v%0d.ready", i), 32'(req_ready), 32'(vecs[i].ready));
      chk($sformatf("v%0d.start", i), 32'(tx_start), 32'(vecs[i].start));
      chk($sformatf("v%0d.data", i), 32'(tx_data), 32'(vecs[i].txd));
      chk($sformatf("v%0d.grant", i), 32'(grant_id), 32'(vecs[i].gid));
      chk($sformatf("v%0d.lock", i), 32'(lock_active), 32'(vecs[i].lock));
      chk($sformatf("v%0d.timeout", i), 32'(lock_timeout), 32'd0);
      step();
    end
    tx_done = 1'b0;

    // Lock timeout: requester 0 sends a non-last byte then goes quiet.
    req_valid = 4'b0001;
    req_last  = 4'b0000;
    req_data  = 32'h33000077;
    #1;
    chk("to.ready0", 32'(req_ready), 32'b0001);
    step();
    req_valid = 4'b1000;
    req_last  = 4'b1000;
    #1;
    chk("to.start", 32'(tx_start), 32'd1);
    chk("to.data", 32'(tx_data), 32'h77);
    step();
    step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    chk("to.lock_set", 32'(lock_active), 32'd1);
    bad = 0;
    k   = 0;
    while (k < 40 && !lock_timeout) begin
      if (req_ready != 4'b0000 || !lock_active) bad++;
      step();
      k++;
    end
    chk("to.cycles", 32'(k), 32'(LT));
    chk("to.masked", 32'(bad), 32'd0);
    chk("to.lock_clr", 32'(lock_active), 32'd0);
    chk("to.ready3", 32'(req_ready), 32'b1000);
    step();
    req_valid = 4'b0000;
    chk("to.pulse1", 32'(lock_timeout), 32'd0);
    chk("to.start3", 32'(tx_start), 32'd1);
    chk("to.data3", 32'(tx_data), 32'h33);
    chk("to.grant3", 32'(grant_id), 32'd3);
    step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;

    // Stray tx_done in IDLE, then a 50-cycle tx_busy stall with a stray done.
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    chk("busy.idle_stray", 32'(tx_start), 32'd0);
    tx_busy   = 1'b1;
    req_valid = 4'b0010;
    req_last  = 4'b0010;
    req_data  = 32'h00008800;
    #1;
    chk("busy.ready1", 32'(req_ready), 32'b0010);
    step();
    req_valid = 4'b0000;
    starts    = 0;
    for (int j = 0; j < 50; j++) begin
      if (tx_start) starts++;
      tx_done = (j == 20);
      step();
    end
    tx_done = 1'b0;
    tx_busy = 1'b0;
    chk("busy.no_start", 32'(starts + int'(tx_start)), 32'd0);
    step();
    chk("busy.start", 32'(tx_start), 32'd1);
    chk("busy.data", 32'(tx_data), 32'h88);
    chk("busy.grant", 32'(grant_id), 32'd1);
    step();
    chk("busy.single", 32'(tx_start), 32'd0);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;

    // Reset while in WAIT_DONE mid-message.
    req_valid = 4'b0100;
    req_last  = 4'b0000;
    req_data  = 32'h00C10000;
    step();
    req_data = 32'h00C20000;
    step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    chk("rst.hold_ready", 32'(req_ready), 32'b0100);
    step();
    req_valid = 4'b0000;
    step();
    chk("rst.pre_lock", 32'(lock_active), 32'd1);
    chk("rst.pre_data", 32'(tx_data), 32'hC2);
    chk("rst.pre_grant", 32'(grant_id), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("rst.async");
    @(negedge clk);
    rst = 1'b0;
    step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    chk_all_zero("rst.after");
    req_valid = 4'b0101;
    req_last  = 4'b0101;
    req_data  = 32'h00C30099;
    #1;
    chk("rst.ready0", 32'(req_ready), 32'b0001);
    step();
    chk("rst.start0", 32'(tx_start), 32'd1);
    chk("rst.data0", 32'(tx_data), 32'h99);
    chk("rst.grant0", 32'(grant_id), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
